// File: rtl/sd_block_reader.sv
// sd_block_reader: SD card single-block (CMD17) reader on the shared SPI byte engine.
// Multiplexes the SPI engine between CPU port traffic (busy=0) and an internal
// sequencer that sends CMD17, polls R1 and the data token, streams 512 data bytes
// with their index, drops the CRC and closes with chip select high plus one trailing byte.
//
// Ports:
//   clock, reset         system clock, asynchronous active-high reset
//   cep, cen             state clock-enable / SPI engine clock-enable (counted in byte waits)
//   start, lba           read request and block address (latched on accepted start)
//   busy, done, error    sequencer owns SPI / end-of-operation pulse / failure flag
//   err_code             1 = R1 nonzero, 2 = timeout, 3 = bad token
//   data_out, data_valid, data_index   received data byte stream
//   cpu_tx, cpu_rx, cpu_d, cpu_cs      CPU side of the SPI path
//   spi_tx, spi_rx, spi_d, spi_q       SPI byte engine side
//   sd_cs                card chip select, active low
module sd_block_reader #(
    parameter int unsigned BYTE_TICKS  = 18,
    parameter int unsigned R1_TRIES    = 8,
    parameter int unsigned TOKEN_TRIES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cep,
    input  logic        cen,
    input  logic        start,
    input  logic [31:0] lba,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic [8:0]  data_index,
    input  logic        cpu_tx,
    input  logic        cpu_rx,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_cs,
    output logic        spi_tx,
    output logic        spi_rx,
    output logic [7:0]  spi_d,
    input  logic [7:0]  spi_q,
    output logic        sd_cs
);

    localparam int unsigned TickW = $clog2(BYTE_TICKS + 1);

    typedef enum logic [2:0] {StIdle, StCmd, StR1, StToken, StData, StCrc, StFinish} state_e;
    typedef enum logic [1:0] {PhStrobe, PhWait, PhSample} phase_e;

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [2:0]       byte_q, byte_d;
    logic [10:0]      try_q, try_d;
    logic [9:0]       cnt_q, cnt_d;
    logic [31:0]      lba_q, lba_d;
    logic             busy_q, busy_d, cs_q, cs_d, done_q, done_d, error_q, error_d;
    logic             dvalid_q, dvalid_d, dummy_q, dummy_d;
    logic [1:0]       err_q, err_d;
    logic [7:0]       dout_q, dout_d;
    logic [8:0]       dindex_q, dindex_d;
    logic [10:0]      try_inc;
    logic [7:0]       cmd_byte;

    assign try_inc = (try_q == 11'h7FF) ? try_q : try_q + 11'd1;

    always_comb begin
        cmd_byte = 8'hFF;
        case (byte_q)
            3'd0:    cmd_byte = 8'h51;
            3'd1:    cmd_byte = lba_q[31:24];
            3'd2:    cmd_byte = lba_q[23:16];
            3'd3:    cmd_byte = lba_q[15:8];
            3'd4:    cmd_byte = lba_q[7:0];
            default: cmd_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        tick_d   = tick_q;
        byte_d   = byte_q;
        try_d    = try_q;
        cnt_d    = cnt_q;
        lba_d    = lba_q;
        busy_d   = busy_q;
        cs_d     = cs_q;
        error_d  = error_q;
        err_d    = err_q;
        dout_d   = dout_q;
        dindex_d = dindex_q;
        dummy_d  = dummy_q;
        // Pulses last exactly one cep period.
        done_d   = cep ? 1'b0 : done_q;
        dvalid_d = cep ? 1'b0 : dvalid_q;

        if (state_q == StIdle) begin
            if (cep && start) begin
                lba_d   = lba;
                error_d = 1'b0;
                err_d   = 2'd0;
                busy_d  = 1'b1;
                cs_d    = 1'b0;
                state_d = StCmd;
                byte_d  = 3'd0;
                try_d   = 11'd0;
                cnt_d   = 10'd0;
                tick_d  = '0;
                // A CPU strobe passing through this cycle owns the engine for one byte;
                // wait it out before our first strobe.
                dummy_d = cpu_tx | cpu_rx;
                phase_d = (cpu_tx | cpu_rx) ? PhWait : PhStrobe;
            end
        end else begin
            case (phase_q)
                PhStrobe: begin
                    if (cep) begin
                        phase_d = PhWait;
                        tick_d  = '0;
                    end
                end
                PhWait: begin
                    // cen is counted on its own, independent of cep.
                    if (cen) begin
                        tick_d = tick_q + 1'b1;
                        if (tick_q == TickW'(BYTE_TICKS - 1)) phase_d = PhSample;
                    end
                end
                PhSample: begin
                    if (cep) begin
                        phase_d = PhStrobe;
                        if (dummy_q) begin
                            dummy_d = 1'b0;
                        end else begin
                            unique case (state_q)
                                StCmd: begin
                                    if (byte_q == 3'd5) begin
                                        state_d = StR1;
                                        try_d   = 11'd0;
                                    end else begin
                                        byte_d = byte_q + 3'd1;
                                    end
                                end
                                StR1: begin
                                    if (!spi_q[7]) begin
                                        if (spi_q == 8'h00) begin
                                            state_d = StToken;
                                            try_d   = 11'd0;
                                        end else begin
                                            err_d = 2'd1; error_d = 1'b1;
                                            state_d = StFinish; cs_d = 1'b1;
                                        end
                                    end else if (32'(try_inc) >= R1_TRIES) begin
                                        err_d = 2'd2; error_d = 1'b1;
                                        state_d = StFinish; cs_d = 1'b1;
                                    end else begin
                                        try_d = try_inc;
                                    end
                                end
                                StToken: begin
                                    if (spi_q == 8'hFE) begin
                                        state_d = StData;
                                        cnt_d   = 10'd0;
                                    end else if (spi_q != 8'hFF) begin
                                        err_d = 2'd3; error_d = 1'b1;
                                        state_d = StFinish; cs_d = 1'b1;
                                    end else if (32'(try_inc) >= TOKEN_TRIES) begin
                                        err_d = 2'd2; error_d = 1'b1;
                                        state_d = StFinish; cs_d = 1'b1;
                                    end else begin
                                        try_d = try_inc;
                                    end
                                end
                                StData: begin
                                    dout_d   = spi_q;
                                    dindex_d = cnt_q[8:0];
                                    dvalid_d = 1'b1;
                                    cnt_d    = (cnt_q == 10'd512) ? cnt_q : cnt_q + 10'd1;
                                    if (cnt_q == 10'd511) begin
                                        state_d = StCrc;
                                        byte_d  = 3'd0;
                                    end
                                end
                                StCrc: begin
                                    if (byte_q == 3'd1) begin
                                        state_d = StFinish;
                                        cs_d    = 1'b1;
                                    end else begin
                                        byte_d = byte_q + 3'd1;
                                    end
                                end
                                StFinish: begin
                                    state_d = StIdle;
                                    busy_d  = 1'b0;
                                    done_d  = 1'b1;
                                end
                                default: state_d = StIdle;
                            endcase
                        end
                    end
                end
                default: phase_d = PhStrobe;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            phase_q  <= PhStrobe;
            tick_q   <= '0;
            byte_q   <= 3'd0;
            try_q    <= 11'd0;
            cnt_q    <= 10'd0;
            lba_q    <= 32'd0;
            busy_q   <= 1'b0;
            cs_q     <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            err_q    <= 2'd0;
            dout_q   <= 8'h00;
            dvalid_q <= 1'b0;
            dindex_q <= 9'd0;
            dummy_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            tick_q   <= tick_d;
            byte_q   <= byte_d;
            try_q    <= try_d;
            cnt_q    <= cnt_d;
            lba_q    <= lba_d;
            busy_q   <= busy_d;
            cs_q     <= cs_d;
            done_q   <= done_d;
            error_q  <= error_d;
            err_q    <= err_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            dindex_q <= dindex_d;
            dummy_q  <= dummy_d;
        end
    end

    logic seq_strobe;
    assign seq_strobe = (phase_q == PhStrobe) && cep && !dummy_q;

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_q;
    assign data_out   = dout_q;
    assign data_valid = dvalid_q;
    assign data_index = dindex_q;
    assign spi_tx     = busy_q ? (seq_strobe && state_q == StCmd) : cpu_tx;
    assign spi_rx     = busy_q ? (seq_strobe && state_q != StCmd) : cpu_rx;
    assign spi_d      = busy_q ? ((state_q == StCmd) ? cmd_byte : 8'hFF) : cpu_d;
    assign sd_cs      = busy_q ? cs_q : cpu_cs;

endmodule

// File: tb/tb_sd_block_reader.sv
// Bench for sd_block_reader: card/SPI-engine model, reference model of the read
// outcome, and a scoreboard monitor checking data bytes and completion status.
module tb_sd_block_reader;

    localparam int unsigned BT  = 3;
    localparam int unsigned R1T = 8;
    localparam int unsigned TKT = 1024;

    logic        clock = 1'b0, reset = 1'b1, cep = 1'b1, cen = 1'b1, start = 1'b0;
    logic [31:0] lba = 32'd0;
    logic        busy, done, error, data_valid, spi_tx, spi_rx, sd_cs;
    logic [1:0]  err_code;
    logic [7:0]  data_out, spi_d;
    logic [8:0]  data_index;
    logic        cpu_tx = 1'b0, cpu_rx = 1'b0, cpu_cs = 1'b0;
    logic [7:0]  cpu_d = 8'h00, spi_q = 8'hFF;

    sd_block_reader #(.BYTE_TICKS(BT), .R1_TRIES(R1T), .TOKEN_TRIES(TKT)) dut (
        .clock(clock), .reset(reset), .cep(cep), .cen(cen), .start(start), .lba(lba),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .data_out(data_out), .data_valid(data_valid), .data_index(data_index),
        .cpu_tx(cpu_tx), .cpu_rx(cpu_rx), .cpu_d(cpu_d), .cpu_cs(cpu_cs),
        .spi_tx(spi_tx), .spi_rx(spi_rx), .spi_d(spi_d), .spi_q(spi_q), .sd_cs(sd_cs)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  code;
        int          rx;
        logic [47:0] cmd;
    } status_t;

    int tests = 0, fails = 0;
    logic [7:0]  scen[$];
    logic [7:0]  card_q[$];
    logic [7:0]  tx_log[$];
    logic [16:0] exp_d[$];
    status_t     exp_st[$];
    int rx_cnt = 0, cs_high_cnt = 0;
    bit last_cs = 1'b0, done_seen = 1'b0, noise_en = 1'b0;
    bit acc_pending = 1'b0, first_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Clock enables, randomly gapped.
    initial forever begin
        @(posedge clock); #1;
        cep = ($urandom_range(0, 9) != 0);
        cen = ($urandom_range(0, 9) < 8);
    end

    // CPU port noise while the sequencer owns the engine.
    initial forever begin
        @(posedge clock); #1;
        if (noise_en && busy) begin
            cpu_tx = 1'($urandom_range(0, 1));
            cpu_rx = 1'($urandom_range(0, 1));
            cpu_d  = 8'($urandom);
            cpu_cs = 1'($urandom_range(0, 1));
        end else if (noise_en) begin
            cpu_tx = 1'b0;
            cpu_rx = 1'b0;
        end
    end

    // Card + SPI engine: answers each sequencer strobe.
    initial forever begin
        @(negedge clock);
        if (!reset && busy && (spi_tx || spi_rx)) begin
            if (sd_cs) cs_high_cnt++;
            last_cs = sd_cs;
            if (spi_tx) begin
                tx_log.push_back(spi_d);
                spi_q = 8'hFF;
            end else begin
                rx_cnt++;
                spi_q = (card_q.size() != 0) ? card_q.pop_front() : 8'hFF;
            end
        end
    end

    // Scoreboard monitor.
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            if (acc_pending) begin
                check("start_busy", busy, 1'b1);
                check("start_cs_low", sd_cs, 1'b0);
                acc_pending   = 1'b0;
                first_pending = 1'b1;
            end
            if (first_pending && cep) begin
                check("first_strobe", {spi_tx, spi_d}, {1'b1, 8'h51});
                first_pending = 1'b0;
            end
            if (!busy && start && cep) acc_pending = 1'b1;
            if (data_valid && cep) begin
                if (exp_d.size() == 0) begin
                    check("unexpected_data", {data_index, data_out}, 17'h1FFFF);
                end else begin
                    logic [16:0] e;
                    e = exp_d.pop_front();
                    check("data_byte", {data_index, data_out}, e);
                end
            end
            if (done && cep) begin
                if (exp_st.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    status_t s;
                    logic [47:0] got;
                    s = exp_st.pop_front();
                    got = 48'd0;
                    foreach (tx_log[i]) got = {got[39:0], tx_log[i]};
                    check("done_error", error, s.code != 2'd0);
                    check("done_err_code", err_code, s.code);
                    check("rx_strobes", rx_cnt, s.rx);
                    check("tx_count", tx_log.size(), 6);
                    check("cmd_bytes", got, s.cmd);
                    check("cs_high_strobes", cs_high_cnt, 1);
                    check("cs_trailing", last_cs, 1'b1);
                    check("data_left", exp_d.size(), 0);
                    check("busy_clear", busy, 1'b0);
                end
                done_seen = 1'b1;
            end
        end
    end

    function automatic logic [7:0] at(input int p);
        return (p < scen.size()) ? scen[p] : 8'hFF;
    endfunction

    // Outcome of a read from the card's byte stream, straight from the protocol rules.
    function automatic void model(input logic [31:0] a);
        status_t    s;
        int         pos = 0;
        bit         fin = 1'b0;
        logic [7:0] b;
        s.code = 2'd2;
        for (int n = 0; n < R1T && !fin; n++) begin
            b = at(pos);
            pos++;
            if (!b[7]) begin
                fin = 1'b1;
                s.code = (b == 8'h00) ? 2'd0 : 2'd1;
            end
        end
        if (fin && s.code == 2'd0) begin
            fin = 1'b0;
            s.code = 2'd2;
            for (int n = 0; n < TKT && !fin; n++) begin
                b = at(pos);
                pos++;
                if (b == 8'hFE) begin
                    fin = 1'b1;
                    s.code = 2'd0;
                end else if (b != 8'hFF) begin
                    fin = 1'b1;
                    s.code = 2'd3;
                end
            end
            if (s.code == 2'd0) begin
                for (int i = 0; i < 512; i++) begin
                    logic [8:0] idx;
                    idx = i[8:0];
                    exp_d.push_back({idx, at(pos)});
                    pos++;
                end
                pos += 2;
            end
        end
        s.rx  = pos + 1;
        s.cmd = {8'h51, a, 8'hFF};
        exp_st.push_back(s);
    endfunction

    task automatic launch(input logic [31:0] a);
        model(a);
        card_q = scen;
        tx_log.delete();
        rx_cnt = 0;
        cs_high_cnt = 0;
        last_cs = 1'b0;
        done_seen = 1'b0;
        @(negedge clock);
        lba = a;
        start = 1'b1;
        for (int i = 0; i < 200 && !busy; i++) @(negedge clock);
        start = 1'b0;
        if (!busy) check("start_timeout", busy, 1'b1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20000 && !done_seen; i++) @(negedge clock);
        if (!done_seen) check("done_timeout", done_seen, 1'b1);
    endtask

    task automatic run_read(input logic [31:0] a);
        launch(a);
        wait_done();
    endtask

    task automatic nominal_scen();
        scen.delete();
        scen.push_back(8'hFF); scen.push_back(8'hFF); scen.push_back(8'h00);
        scen.push_back(8'hFE);
        for (int i = 0; i < 512; i++) scen.push_back(8'(i));
        scen.push_back(8'hA5); scen.push_back(8'h5A);
    endtask

    task automatic rand_scen();
        int n;
        scen.delete();
        n = $urandom_range(0, 3);
        repeat (n) scen.push_back(8'h80 | 8'($urandom));
        scen.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 127)) : 8'h00);
        n = $urandom_range(0, 5);
        repeat (n) scen.push_back(8'hFF);
        scen.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 253)) : 8'hFE);
        for (int i = 0; i < 514; i++) scen.push_back(8'($urandom));
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_outs", {done, error, err_code, data_valid, data_index, data_out}, 22'd0);
        reset = 1'b0;
        @(negedge clock);

        // Idle pass-through, same cycle.
        cpu_tx = 1'b1; cpu_d = 8'h3C; cpu_cs = 1'b1;
        #1 check("pass_tx", {spi_tx, spi_rx, spi_d, sd_cs}, {1'b1, 1'b0, 8'h3C, 1'b1});
        cpu_tx = 1'b0; cpu_rx = 1'b1; cpu_d = 8'hC3; cpu_cs = 1'b0;
        #1 check("pass_rx", {spi_tx, spi_rx, spi_d, sd_cs}, {1'b0, 1'b1, 8'hC3, 1'b0});
        cpu_rx = 1'b0;
        noise_en = 1'b1;

        nominal_scen();
        run_read(32'h0000_1234);

        scen.delete(); scen.push_back(8'h05);
        run_read(32'hDEAD_BEEF);

        scen.delete();
        run_read(32'h0000_0001);

        scen.delete(); scen.push_back(8'h00);
        run_read(32'h0000_0002);

        scen.delete(); scen.push_back(8'h00); scen.push_back(8'hFF); scen.push_back(8'hFC);
        run_read(32'h8000_0000);

        // Reset mid-block at index 100.
        nominal_scen();
        launch(32'h0000_4321);
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 20000 && !hit; i++) begin
                @(negedge clock);
                hit = data_valid && cep && (data_index == 9'd100);
            end
            if (!hit) check("idx100_timeout", hit, 1'b1);
        end
        noise_en = 1'b0;
        cpu_tx = 1'b0; cpu_rx = 1'b0; cpu_cs = 1'b1; cpu_d = 8'h77;
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_outs", {done, error, err_code, data_valid, data_index, data_out}, 22'd0);
        check("midrst_spi", {spi_tx, spi_rx, spi_d, sd_cs}, {1'b0, 1'b0, 8'h77, 1'b1});
        exp_d.delete();
        exp_st.delete();
        acc_pending = 1'b0;
        first_pending = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        cpu_cs = 1'b0;
        noise_en = 1'b1;
        nominal_scen();
        run_read(32'h0000_4321);

        for (int k = 0; k < 4; k++) begin
            rand_scen();
            run_read($urandom);
        end

        repeat (5) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
